sync_vq_fifo: RTL and testbench
===============================

# sync_vq_fifo

Multi-queue synchronous FIFO: QUEUE_NUM logical queues of equal depth, statically partitioned in one shared dual-port RAM (dpram_sclk), with per-queue full/empty/almost-full/count status and single-cycle queue flush. Sits in the switch ingress path as the virtual-output-queue buffer: one write port is steered by destination queue id, and one read port is driven by the output scheduler. Successor to the single-queue sync FIFO; adds queue addressing, a registered read-data-valid, an almost-full threshold, flush, and accept-on-full when a simultaneous read frees a slot.

## Interface
- ADDR_WIDTH, 9: log2 of per-queue depth (DEPTH = 1<<ADDR_WIDTH)
- DATA_WIDTH, 16: word width
- QUEUE_NUM, 4: number of queues, power of two, ≥2
- QID_WIDTH, 2: equals log2(QUEUE_NUM)
- AFULL_THRESH, DEPTH-4: almost_full asserts when count ≥ this value
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_qid  in  QID_WIDTH  target queue of write
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request
- rd_qid  in  QID_WIDTH  source queue of read
- rd_data  out  DATA_WIDTH  read word, valid when rd_valid=1
- rd_valid  out  1  one-cycle pulse, one cycle after an accepted read
- flush_en  in  1  clear queue flush_qid
- flush_qid  in  QID_WIDTH  queue to flush
- full  out  QUEUE_NUM  bit q: count[q]==DEPTH
- empty  out  QUEUE_NUM  bit q: count[q]==0
- almost_full  out  QUEUE_NUM  bit q: count[q]≥AFULL_THRESH
- wr_err  out  1  registered pulse: write rejected
- rd_err  out  1  registered pulse: read rejected
- data_count  out  QUEUE_NUM*(ADDR_WIDTH+1)  packed counts, queue q at bits [q*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]

## Operation
- RAM depth QUEUE_NUM*DEPTH; physical address = {qid, local pointer}. Per queue: rd_ptr, wr_ptr (ADDR_WIDTH bits, natural wrap), count (ADDR_WIDTH+1 bits).
- Read accepted iff rd_en && !empty[rd_qid] && !(flush_en && flush_qid==rd_qid). Otherwise, if rd_en, pulse rd_err (except flush collision: silent drop).
- Write accepted iff wr_en && !(flush_en && flush_qid==wr_qid) && (!full[wr_qid] || read accepted on same qid this cycle). Otherwise, if wr_en, pulse wr_err (except flush collision: silent drop).
- Accepted write: RAM[wr_qid, wr_ptr] ← wr_data, wr_ptr+1. Accepted read: rd_ptr+1.
- count update per queue: +1 write only, −1 read only, unchanged for both/neither.
- Flush q: rd_ptr, wr_ptr, count of q ← 0 at next edge; other queues unaffected. Flush has priority over any read/write to q in that cycle.
- Read and write to the same queue while empty: write accepted, read rejected (rd_err); no bypass.
- Read and write to the same queue while full: both accepted; addresses coincide, so RAM must be read-first (read returns the old word). dpram_sclk is instantiated with ENABLE_BYPASS=0, CLEAR_ON_INIT=1.
- Reads and writes to different queues are fully independent.

## Timing
- Reset (async assert): all pointers/counts 0; empty all 1; full, almost_full 0; rd_valid, wr_err, rd_err 0; rd_data 0. Reset mid-operation discards all contents and any in-flight read (rd_valid does not fire).
- Read latency 1: accepted read at edge N → rd_data/rd_valid valid during cycle N+1; rd_data holds its last value when rd_valid=0.
- Status flags and data_count are combinational from registered counts; they reflect edge-N operations in cycle N+1.
- wr_err/rd_err are registered, asserted in cycle N+1 for a rejection at edge N.
- Back-to-back reads every cycle sustain one word per cycle.

## Structure
- Shared package switch_fifo_pkg: QID/count width helper function (clog2) and default DEPTH/threshold constants.
- Sub-module sync_vq_ctrl (one per queue, generate loop): pointers, count, flags, taking per-queue wr_acc/rd_acc/flush strobes. The top holds arbitration of accept/error, address muxing, the RAM, and output registers.

## Test plan
- Reset, write 0x0001..0x0003 to q2, read q2 three times → rd_data 0x0001,0x0002,0x0003 each one cycle after rd_en; empty[2]=1 afterwards.
- Fill q0 with 512 words (ADDR_WIDTH=9) → full[0]=1, almost_full[0] from count 508; a 513th write → wr_err pulse, count stays 512.
- q0 full, simultaneous read q0 + write 0xBEEF → both accepted, rd_data = oldest word, count 512; drain → 0xBEEF last.
- q1 empty, simultaneous write + read q1 → rd_err pulse, count[1]=1, no rd_valid.
- q3 holding 10 words, flush_en q3 with concurrent write to q3 and read from q0 → count[3]=0, no wr_err, q0 read completes normally.
- Assert rst_n low with a read accepted the edge before → rd_valid stays 0, all empty=1, all counts 0.

Source files
------------

// File: rtl/switch_fifo_pkg.sv
// rtl/switch_fifo_pkg.sv - shared constants and width helper for the switch queue buffers
package switch_fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH   = 9;
  localparam int DEFAULT_DATA_WIDTH   = 16;
  localparam int DEFAULT_QUEUE_NUM    = 4;
  localparam int DEFAULT_DEPTH        = 1 << DEFAULT_ADDR_WIDTH;
  localparam int DEFAULT_AFULL_THRESH = DEFAULT_DEPTH - 4;

  // Ceiling log2, used to size queue ids from the queue count
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dpram_sclk.sv
// rtl/dpram_sclk.sv - single-clock simple dual-port RAM with registered read
module dpram_sclk #(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_WIDTH    = 16,
  parameter bit ENABLE_BYPASS = 1'b0,
  parameter bit CLEAR_ON_INIT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic [DATA_WIDTH-1:0] rd_word;

  // Without bypass a colliding read sees the word stored before this edge
  generate
    if (ENABLE_BYPASS) begin : g_bypass
      assign rd_word = (we && (waddr == raddr)) ? wdata : mem[raddr];
    end else begin : g_read_first
      assign rd_word = mem[raddr];
    end
  endgenerate

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register only loads on a read, so it holds its last word otherwise
  generate
    if (CLEAR_ON_INIT) begin : g_clear
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata <= '0;
        end else if (re) begin
          rdata <= rd_word;
        end
      end
    end else begin : g_no_clear
      always_ff @(posedge clk) begin
        if (re) begin
          rdata <= rd_word;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/sync_vq_ctrl.sv
// rtl/sync_vq_ctrl.sv - per-queue pointers, occupancy count and status flags
module sync_vq_ctrl
  import switch_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int AFULL_THRESH = DEFAULT_AFULL_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_acc,
  input  logic                  rd_acc,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_THRESH);

  // Flush wins over any access to this queue; simultaneous read+write leaves count alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign almost_full = (count >= AFULL_CNT);

endmodule

// File: rtl/sync_vq_fifo.sv
// rtl/sync_vq_fifo.sv - multi-queue FIFO over one shared RAM with per-queue status and flush
module sync_vq_fifo
  import switch_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int QUEUE_NUM    = DEFAULT_QUEUE_NUM,
  parameter int QID_WIDTH    = clog2(QUEUE_NUM),
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - (DEFAULT_DEPTH - DEFAULT_AFULL_THRESH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [QID_WIDTH-1:0]              wr_qid,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              rd_en,
  input  logic [QID_WIDTH-1:0]              rd_qid,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              rd_valid,
  input  logic                              flush_en,
  input  logic [QID_WIDTH-1:0]              flush_qid,
  output logic [QUEUE_NUM-1:0]              full,
  output logic [QUEUE_NUM-1:0]              empty,
  output logic [QUEUE_NUM-1:0]              almost_full,
  output logic                              wr_err,
  output logic                              rd_err,
  output logic [QUEUE_NUM*(ADDR_WIDTH+1)-1:0] data_count
);

  localparam int RAM_AW = QID_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr_arr [QUEUE_NUM];
  logic [ADDR_WIDTH-1:0] rd_ptr_arr [QUEUE_NUM];
  logic [QUEUE_NUM-1:0]  wr_acc_vec;
  logic [QUEUE_NUM-1:0]  rd_acc_vec;
  logic [QUEUE_NUM-1:0]  flush_vec;

  logic wr_flush_hit;
  logic rd_flush_hit;
  logic rd_acc;
  logic wr_acc;

  // A flush on the addressed queue silently drops the access instead of flagging an error
  assign rd_flush_hit = flush_en && (flush_qid == rd_qid);
  assign wr_flush_hit = flush_en && (flush_qid == wr_qid);
  assign rd_acc = rd_en && !empty[rd_qid] && !rd_flush_hit;
  // A full queue still takes a write when the same cycle's read frees a slot
  assign wr_acc = wr_en && !wr_flush_hit &&
                  (!full[wr_qid] || (rd_acc && (rd_qid == wr_qid)));

  generate
    for (genvar q = 0; q < QUEUE_NUM; q++) begin : g_queue
      assign wr_acc_vec[q] = wr_acc && (wr_qid == QID_WIDTH'(q));
      assign rd_acc_vec[q] = rd_acc && (rd_qid == QID_WIDTH'(q));
      assign flush_vec[q]  = flush_en && (flush_qid == QID_WIDTH'(q));

      sync_vq_ctrl #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .AFULL_THRESH (AFULL_THRESH)
      ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_acc      (wr_acc_vec[q]),
        .rd_acc      (rd_acc_vec[q]),
        .flush       (flush_vec[q]),
        .wr_ptr      (wr_ptr_arr[q]),
        .rd_ptr      (rd_ptr_arr[q]),
        .count       (data_count[q*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]),
        .full        (full[q]),
        .empty       (empty[q]),
        .almost_full (almost_full[q])
      );
    end
  endgenerate

  logic [RAM_AW-1:0] ram_waddr;
  logic [RAM_AW-1:0] ram_raddr;

  assign ram_waddr = {wr_qid, wr_ptr_arr[wr_qid]};
  assign ram_raddr = {rd_qid, rd_ptr_arr[rd_qid]};

  // Read-first so a full queue read+write on the same slot returns the old word
  dpram_sclk #(
    .ADDR_WIDTH    (RAM_AW),
    .DATA_WIDTH    (DATA_WIDTH),
    .ENABLE_BYPASS (1'b0),
    .CLEAR_ON_INIT (1'b1)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (ram_waddr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (ram_raddr),
    .rdata (rd_data)
  );

  // Registered read-valid and rejection pulses, aligned with the RAM output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      wr_err   <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      wr_err   <= wr_en && !wr_acc && !wr_flush_hit;
      rd_err   <= rd_en && !rd_acc && !rd_flush_hit;
    end
  end

endmodule

// File: tb/tb_sync_vq_fifo.sv
// tb/tb_sync_vq_fifo.sv - directed self-checking bench for sync_vq_fifo
module tb_sync_vq_fifo;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_qid;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [1:0]  rd_qid;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        flush_en;
  logic [1:0]  flush_qid;
  logic [3:0]  full;
  logic [3:0]  empty;
  logic [3:0]  almost_full;
  logic        wr_err;
  logic        rd_err;
  logic [39:0] data_count;

  int n_tests;
  int n_fail;

  sync_vq_fifo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_qid      (wr_qid),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_qid      (rd_qid),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .flush_en    (flush_en),
    .flush_qid   (flush_qid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .wr_err      (wr_err),
    .rd_err      (rd_err),
    .data_count  (data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] cnt(input int q);
    return data_count[q*10 +: 10];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    flush_en = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_word;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    wr_qid    = 2'd0;
    wr_data   = 16'h0;
    rd_qid    = 2'd0;
    flush_qid = 2'd0;
    idle();
    tick();
    tick();

    check_eq("rst_empty", 32'(empty), 32'hF);
    check_eq("rst_full", 32'(full), 32'h0);
    check_eq("rst_afull", 32'(almost_full), 32'h0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
    check_eq("rst_errs", 32'({wr_err, rd_err}), 32'h0);
    check_eq("rst_rd_data", 32'(rd_data), 32'h0);
    check_eq("rst_counts_lo", data_count[31:0], 32'h0);
    check_eq("rst_counts_hi", 32'(data_count[39:32]), 32'h0);

    rst_n = 1'b1;
    tick();

    // Three words through q2, read back to back
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_qid = 2'd2; wr_data = 16'(i);
      tick();
    end
    idle();
    check_eq("q2_count3", 32'(cnt(2)), 32'd3);
    check_eq("q2_empty_mask", 32'(empty), 32'hB);
    rd_en = 1'b1; rd_qid = 2'd2;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("q2_rd_valid", 32'(rd_valid), 32'h1);
      check_eq("q2_rd_data", 32'(rd_data), 32'(i));
    end
    idle();
    check_eq("q2_empty_after", 32'(empty[2]), 32'h1);
    tick();
    check_eq("q2_valid_drop", 32'(rd_valid), 32'h0);
    check_eq("q2_data_hold", 32'(rd_data), 32'h3);

    // Fill q0 completely, watching the almost-full threshold
    for (int i = 0; i < 512; i++) begin
      wr_en = 1'b1; wr_qid = 2'd0; wr_data = 16'(i);
      tick();
      if (i + 1 == 507) check_eq("q0_afull_507", 32'(almost_full[0]), 32'h0);
      if (i + 1 == 508) check_eq("q0_afull_508", 32'(almost_full[0]), 32'h1);
      if (i + 1 == 511) check_eq("q0_full_511", 32'(full[0]), 32'h0);
    end
    idle();
    check_eq("q0_count512", 32'(cnt(0)), 32'd512);
    check_eq("q0_full", 32'(full[0]), 32'h1);
    check_eq("q0_wr_err_none", 32'(wr_err), 32'h0);
    wr_en = 1'b1; wr_qid = 2'd0; wr_data = 16'hDEAD;
    tick();
    idle();
    check_eq("q0_overflow_err", 32'(wr_err), 32'h1);
    check_eq("q0_overflow_count", 32'(cnt(0)), 32'd512);
    tick();
    check_eq("q0_err_pulse_end", 32'(wr_err), 32'h0);

    // Full queue: simultaneous read and write both accepted
    wr_en = 1'b1; wr_qid = 2'd0; wr_data = 16'hBEEF;
    rd_en = 1'b1; rd_qid = 2'd0;
    tick();
    idle();
    check_eq("fullrw_valid", 32'(rd_valid), 32'h1);
    check_eq("fullrw_data", 32'(rd_data), 32'h0);
    check_eq("fullrw_count", 32'(cnt(0)), 32'd512);
    check_eq("fullrw_errs", 32'({wr_err, rd_err}), 32'h0);
    rd_en = 1'b1; rd_qid = 2'd0;
    for (int k = 0; k < 512; k++) begin
      tick();
      exp_word = (k < 511) ? 16'(k + 1) : 16'hBEEF;
      check_eq("drain_q0", 32'({rd_valid, rd_data}), 32'({1'b1, exp_word}));
    end
    idle();
    check_eq("q0_empty_after", 32'(empty[0]), 32'h1);

    // Empty queue: simultaneous write and read, no bypass
    wr_en = 1'b1; wr_qid = 2'd1; wr_data = 16'h1111;
    rd_en = 1'b1; rd_qid = 2'd1;
    tick();
    idle();
    check_eq("q1_rd_err", 32'(rd_err), 32'h1);
    check_eq("q1_no_valid", 32'(rd_valid), 32'h0);
    check_eq("q1_count1", 32'(cnt(1)), 32'd1);
    check_eq("q1_no_wr_err", 32'(wr_err), 32'h0);

    // Flush q3 with colliding write, concurrent independent read of q0
    wr_en = 1'b1; wr_qid = 2'd0; wr_data = 16'h0A5A;
    tick();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_qid = 2'd3; wr_data = 16'(16'h300 + i);
      tick();
    end
    idle();
    check_eq("q3_count10", 32'(cnt(3)), 32'd10);
    flush_en = 1'b1; flush_qid = 2'd3;
    wr_en = 1'b1; wr_qid = 2'd3; wr_data = 16'h7777;
    rd_en = 1'b1; rd_qid = 2'd0;
    tick();
    idle();
    check_eq("flush_q3_count", 32'(cnt(3)), 32'd0);
    check_eq("flush_q3_empty", 32'(empty[3]), 32'h1);
    check_eq("flush_no_wr_err", 32'(wr_err), 32'h0);
    check_eq("flush_q0_valid", 32'(rd_valid), 32'h1);
    check_eq("flush_q0_data", 32'(rd_data), 32'h0A5A);
    check_eq("flush_q0_count", 32'(cnt(0)), 32'd0);
    check_eq("flush_q1_kept", 32'(cnt(1)), 32'd1);

    // Reset right after a read is accepted discards it
    rd_en = 1'b1; rd_qid = 2'd1;
    tick();
    rst_n = 1'b0;
    idle();
    #1;
    check_eq("midrst_valid", 32'(rd_valid), 32'h0);
    check_eq("midrst_empty", 32'(empty), 32'hF);
    check_eq("midrst_counts", data_count[31:0] | 32'(data_count[39:32]), 32'h0);
    check_eq("midrst_rd_data", 32'(rd_data), 32'h0);
    tick();
    check_eq("midrst_valid_hold", 32'(rd_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
